mult_datapath: RTL and testbench

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_datapath.sv | 111 +++++++++++
 tb/tb_mult_datapath.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Shift-free multiply datapath: operand A, down-counter B and accumulator P,
// steered by an external control FSM via load/accumulate/decrement strobes.
module mult_datapath #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     data_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_p,
    input  logic             dec,
    input  logic             clr,
    output logic             eqz,
    output logic [2*W-1:0]   product,
    output logic             err,
    output logic [W-1:0]     acc_cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] p_r;
    logic [W-1:0]   cnt_r;
    logic           err_r;

    logic [W-1:0]   a_nxt_s;
    logic [W-1:0]   b_nxt_s;
    logic [2*W-1:0] p_nxt_s;
    logic [W-1:0]   cnt_nxt_s;
    logic           err_nxt_s;
    logic           b_zero_s;

    assign b_zero_s = (b_r == {W{1'b0}});

    // Operand register A: load or hold.
    always_comb begin
        a_nxt_s = a_r;
        if (ld_a) begin
            a_nxt_s = data_in;
        end else begin
            a_nxt_s = a_r;
        end
    end

    // Counter B and sticky underflow flag; a fresh load beats decrement and clears err.
    always_comb begin
        b_nxt_s   = b_r;
        err_nxt_s = err_r;
        if (ld_b) begin
            b_nxt_s   = data_in;
            err_nxt_s = 1'b0;
        end else if (dec) begin
            if (b_zero_s) begin
                b_nxt_s   = {W{1'b0}};
                err_nxt_s = 1'b1;
            end else begin
                b_nxt_s   = b_r - {{(W-1){1'b0}}, 1'b1};
                err_nxt_s = err_r;
            end
        end else begin
            b_nxt_s   = b_r;
            err_nxt_s = err_r;
        end
    end

    // Accumulator P and saturating accumulation count; clr beats ld_p, sum wraps mod 2^(2W).
    always_comb begin
        p_nxt_s   = p_r;
        cnt_nxt_s = cnt_r;
        if (clr) begin
            p_nxt_s   = {(2*W){1'b0}};
            cnt_nxt_s = {W{1'b0}};
        end else if (ld_p) begin
            p_nxt_s = p_r + {{W{1'b0}}, a_r};
            if (cnt_r == CNT_MAX) begin
                cnt_nxt_s = CNT_MAX;
            end else begin
                cnt_nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
            end
        end else begin
            p_nxt_s   = p_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers with synchronous reset overriding every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
            p_r   <= {(2*W){1'b0}};
            cnt_r <= {W{1'b0}};
            err_r <= 1'b0;
        end else begin
            a_r   <= a_nxt_s;
            b_r   <= b_nxt_s;
            p_r   <= p_nxt_s;
            cnt_r <= cnt_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    // eqz is decoded straight from B so the FSM sees it with zero latency.
    assign eqz     = b_zero_s;
    assign product = p_r;
    assign err     = err_r;
    assign acc_cnt = cnt_r;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: arithmetic reference model compared every
// cycle, plus hand-computed checkpoints for the documented scenarios.
module tb_mult_datapath;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst, ld_a, ld_b, ld_p, dec, clr;
    logic [W-1:0]     data_in;
    logic             eqz, err;
    logic [2*W-1:0]   product;
    logic [W-1:0]     acc_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // reference state as plain integers
    longint m_a = 0, m_b = 0, m_p = 0, m_cnt = 0;
    bit     m_err = 1'b0;

    mult_datapath #(.W(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .ld_a(ld_a), .ld_b(ld_b), .ld_p(ld_p), .dec(dec), .clr(clr),
        .eqz(eqz), .product(product), .err(err), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: next state from the documented rules using pre-edge values.
    always @(posedge clk) begin
        longint a_old;
        a_old = m_a;
        if (rst) begin
            m_a = 0; m_b = 0; m_p = 0; m_cnt = 0; m_err = 1'b0;
        end else begin
            if (ld_a) m_a = data_in;
            if (ld_b) begin
                m_b = data_in;
                m_err = 1'b0;
            end else if (dec) begin
                if (m_b == 0) m_err = 1'b1;
                else m_b = m_b - 1;
            end
            if (clr) begin
                m_p = 0; m_cnt = 0;
            end else if (ld_p) begin
                m_p = (m_p + a_old) % (64'd1 << (2*W));
                m_cnt = (m_cnt + 1 > (1 << W) - 1) ? (1 << W) - 1 : m_cnt + 1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp++;
            if (eqz !== (m_b == 0) || product !== m_p[2*W-1:0] ||
                err !== m_err || acc_cnt !== m_cnt[W-1:0]) begin
                n_bad++;
                $display("FAIL model t=%0t got eqz=%0b p=%0d err=%0b cnt=%0d want eqz=%0b p=%0d err=%0b cnt=%0d",
                         $time, eqz, product, err, acc_cnt, (m_b == 0), m_p, m_err, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock with the given strobes; returns 1 time unit after the edge.
    task automatic cyc(input bit r, input bit la, input bit lb, input bit lp,
                       input bit d, input bit c, input int val);
        rst = r; ld_a = la; ld_b = lb; ld_p = lp; dec = d; clr = c;
        data_in = val[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nominal(input int a, input int b);
        cyc(0, 1, 0, 0, 0, 0, a);
        cyc(0, 0, 1, 0, 0, 1, b);
        for (int i = 0; i < b; i++) cyc(0, 0, 0, 1, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ld_a = 1'b0; ld_b = 1'b0; ld_p = 1'b0; dec = 1'b0; clr = 1'b0;
        data_in = '0;
        cyc(1, 1, 1, 1, 1, 0, 8'hAA);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        chk("rst_eqz", eqz, 1);
        chk("rst_product", product, 0);
        chk("rst_err", err, 0);
        chk("rst_acc", acc_cnt, 0);

        // nominal 5 x 3
        cyc(0, 1, 0, 0, 0, 0, 5);
        cyc(0, 0, 1, 0, 0, 1, 3);
        chk("nom_eqz_loaded", eqz, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("nom_mid_p", product, 10);
        chk("nom_mid_eqz", eqz, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("nom_product", product, 15);
        chk("nom_eqz", eqz, 1);
        chk("nom_acc", acc_cnt, 3);
        chk("nom_err", err, 0);
        idle();

        // zero multiplier
        cyc(0, 1, 0, 0, 0, 0, 9);
        cyc(0, 0, 1, 0, 0, 1, 0);
        chk("zero_eqz", eqz, 1);
        chk("zero_product", product, 0);

        // clr beats ld_p; ld_b beats dec
        cyc(0, 1, 0, 0, 0, 0, 20);
        cyc(0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("prio_p20", product, 20);
        cyc(0, 0, 0, 1, 0, 1, 0);
        chk("prio_clr_p", product, 0);
        chk("prio_clr_acc", acc_cnt, 0);
        cyc(0, 0, 1, 0, 1, 0, 7);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("prio_b7_eqz6", eqz, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("prio_b7_eqz7", eqz, 1);

        // underflow
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("uf_err", err, 1);
        chk("uf_eqz", eqz, 1);
        for (int i = 0; i < 3; i++) idle();
        chk("uf_err_held", err, 1);
        cyc(0, 0, 1, 0, 0, 0, 4);
        chk("uf_err_clr", err, 0);
        chk("uf_eqz_b4", eqz, 0);

        // ld_a with ld_p uses the old A
        cyc(0, 1, 0, 0, 0, 1, 10);
        cyc(0, 1, 0, 1, 0, 0, 3);
        chk("olda_p", product, 10);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("newa_p", product, 13);

        // ld_a and ld_b share data_in
        cyc(0, 1, 1, 0, 0, 1, 6);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 0, 0);
        chk("ab_same_p", product, 36);
        chk("ab_same_eqz", eqz, 1);

        // max operands, then saturation and wrap
        nominal(255, 255);
        chk("max_product", product, 65025);
        chk("max_acc", acc_cnt, 255);
        chk("max_eqz", eqz, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("sat_acc", acc_cnt, 255);
        chk("sat_p", product, 65280);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("wrap_p", product, 254);

        // reset mid-multiply, then 4 x 6
        cyc(0, 1, 0, 0, 0, 0, 7);
        cyc(0, 0, 1, 0, 0, 1, 6);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("abort_mid_p", product, 14);
        cyc(1, 0, 0, 1, 1, 0, 0);
        chk("abort_p", product, 0);
        chk("abort_eqz", eqz, 1);
        chk("abort_err", err, 0);
        chk("abort_acc", acc_cnt, 0);
        nominal(4, 6);
        chk("post_rst_product", product, 24);
        chk("post_rst_acc", acc_cnt, 6);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
